// File: rtl/stepper_pkg.sv
// Shared constants for the multi-channel stepper controller: coil table,
// step sizes and per-channel bit-slice layout.
package stepper_pkg;

    localparam int RF_PER_CH  = 2;
    localparam int RF_DIR_OFS = 0;
    localparam int RF_EN_OFS  = 1;
    localparam int COIL_W     = 4;

    localparam logic [2:0] STEP_HALF = 3'd1;
    localparam logic [2:0] STEP_FULL = 3'd2;

    // Entry n is the unipolar coil pattern for phase index n.
    localparam logic [7:0][3:0] COIL_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

endpackage

// File: rtl/stepper_channel.sv
// One stepper channel: button synchronisation and toggle latches, limit
// gating, phase index / signed position registers and coil lookup.
module stepper_channel
    import stepper_pkg::*;
#(
    parameter int POS_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [RF_PER_CH-1:0]    rf_i,
    input  logic                    limit_i,
    input  logic                    half_step_i,
    input  logic                    tick_i,
    output logic [COIL_W-1:0]       coil_o,
    output logic                    dir_o,
    output logic                    en_o,
    output logic signed [POS_W-1:0] pos_o
);

    logic [RF_PER_CH-1:0]    rf_s1_q, rf_s2_q, rf_dly_q;
    logic                    lim_s1_q, lim_s2_q;
    logic                    dir_q, dir_d;
    logic                    en_q, en_d;
    logic [2:0]              idx_q, idx_d;
    logic signed [POS_W-1:0] pos_q, pos_d;

    logic [RF_PER_CH-1:0]    rf_rise;
    logic                    step_en;
    logic [2:0]              step_amt;
    logic signed [POS_W-1:0] pos_delta;

    assign rf_rise   = rf_s2_q & ~rf_dly_q;
    // Forward motion stops on the limit; reverse always allowed to back off it.
    assign step_en   = tick_i & en_q & ~(lim_s2_q & dir_q);
    assign step_amt  = half_step_i ? STEP_HALF : STEP_FULL;
    assign pos_delta = POS_W'(step_amt);

    always_comb begin
        dir_d = dir_q ^ rf_rise[RF_DIR_OFS];
        en_d  = en_q ^ rf_rise[RF_EN_OFS];
        idx_d = idx_q;
        pos_d = pos_q;
        if (step_en) begin
            if (dir_q) begin
                idx_d = idx_q + step_amt;
                pos_d = pos_q + pos_delta;
            end else begin
                idx_d = idx_q - step_amt;
                pos_d = pos_q - pos_delta;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_s1_q  <= '0;
            rf_s2_q  <= '0;
            rf_dly_q <= '0;
            lim_s1_q <= 1'b0;
            lim_s2_q <= 1'b0;
            dir_q    <= 1'b0;
            en_q     <= 1'b0;
            idx_q    <= '0;
            pos_q    <= '0;
        end else begin
            rf_s1_q  <= rf_i;
            rf_s2_q  <= rf_s1_q;
            rf_dly_q <= rf_s2_q;
            lim_s1_q <= limit_i;
            lim_s2_q <= lim_s1_q;
            dir_q    <= dir_d;
            en_q     <= en_d;
            idx_q    <= idx_d;
            pos_q    <= pos_d;
        end
    end

    // Disabled channel de-energises its coils but keeps its phase index.
    assign coil_o = en_q ? COIL_TABLE[idx_q] : '0;
    assign dir_o  = dir_q;
    assign en_o   = en_q;
    assign pos_o  = pos_q;

endmodule

// File: rtl/multi_stepper_controller.sv
// N-channel stepper controller top: shared step-tick divider feeding an
// array of independent stepper_channel instances.
module multi_stepper_controller
    import stepper_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int STEP_DIV = 1_000_000,
    parameter int DIV_W    = 24,
    parameter int POS_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [RF_PER_CH*NUM_CH-1:0] rf_in,
    input  logic [NUM_CH-1:0]           limit_sw,
    input  logic                        half_step,
    output logic [COIL_W*NUM_CH-1:0]    coil_out,
    output logic [NUM_CH-1:0]           dir_out,
    output logic [NUM_CH-1:0]           en_out,
    output logic [POS_W*NUM_CH-1:0]     pos_out
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick;

    assign tick  = (cnt_q == DIV_W'(STEP_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stepper_channel #(
            .POS_W (POS_W)
        ) u_ch (
            .clk_i       (clk),
            .rst_ni      (rst),
            .rf_i        (rf_in[RF_PER_CH*i +: RF_PER_CH]),
            .limit_i     (limit_sw[i]),
            .half_step_i (half_step),
            .tick_i      (tick),
            .coil_o      (coil_out[COIL_W*i +: COIL_W]),
            .dir_o       (dir_out[i]),
            .en_o        (en_out[i]),
            .pos_o       (pos_out[POS_W*i +: POS_W])
        );
    end

endmodule

// File: tb/tb_multi_stepper_controller.sv
// Directed bench for multi_stepper_controller (STEP_DIV=4, NUM_CH=2), with a
// second 4-bit-position instance to reach the signed position wrap cheaply.
module tb_multi_stepper_controller;

    localparam int NUM_CH   = 2;
    localparam int STEP_DIV = 4;
    localparam int DIV_W    = 4;
    localparam int POS_W    = 16;
    localparam int POS_WS   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  rf_in = '0;
    logic [1:0]  limit_sw = '0;
    logic        half_step = 1'b0;

    logic [7:0]  coil_out;
    logic [1:0]  dir_out, en_out;
    logic [31:0] pos_out;

    logic [7:0]  s_coil;
    logic [1:0]  s_dir, s_en;
    logic [7:0]  s_pos;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    multi_stepper_controller #(
        .NUM_CH(NUM_CH), .STEP_DIV(STEP_DIV), .DIV_W(DIV_W), .POS_W(POS_W)
    ) dut (
        .clk(clk), .rst(rst), .rf_in(rf_in), .limit_sw(limit_sw),
        .half_step(half_step), .coil_out(coil_out), .dir_out(dir_out),
        .en_out(en_out), .pos_out(pos_out)
    );

    multi_stepper_controller #(
        .NUM_CH(NUM_CH), .STEP_DIV(STEP_DIV), .DIV_W(DIV_W), .POS_W(POS_WS)
    ) dut_small (
        .clk(clk), .rst(rst), .rf_in(rf_in), .limit_sw(limit_sw),
        .half_step(half_step), .coil_out(s_coil), .dir_out(s_dir),
        .en_out(s_en), .pos_out(s_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic wait_to(input int n);
        while (edges < n) cyc();
    endtask

    initial begin
        #1;
        chk("reset_outs", {coil_out, en_out, dir_out, pos_out}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        edges = 0;

        // Idle after reset
        for (int i = 0; i < 40; i++) begin
            cyc();
            chk("idle_outs", {coil_out, en_out, dir_out, pos_out}, 64'd0);
        end

        // Enable ch0, half step, reverse
        half_step = 1'b1;
        rf_in[1]  = 1'b1;
        wait_to(42);
        chk("en_before_edge2", en_out, 2'b00);
        wait_to(43);
        chk("en_rise", en_out, 2'b01);
        chk("coil_en_idx0", coil_out, 8'h08);
        chk("pos_before_step", pos_out, 32'h0);
        wait_to(44);
        chk("coil_hs_idx7", coil_out, 8'h09);
        chk("pos_m1", pos_out, 32'h0000_FFFF);
        wait_to(45);
        rf_in[1] = 1'b0;
        chk("coil_hold", coil_out, 8'h09);
        wait_to(48);
        chk("coil_hs_idx6", coil_out, 8'h01);
        chk("pos_m2", pos_out, 32'h0000_FFFE);
        wait_to(52);
        chk("coil_hs_idx5", coil_out, 8'h03);
        chk("pos_m3", pos_out, 32'h0000_FFFD);
        chk("en_single_toggle", en_out, 2'b01);
        wait_to(72);
        chk("coil_back_idx0", coil_out, 8'h08);
        chk("pos_m8", pos_out, 32'h0000_FFF8);
        chk("small_pos_m8", s_pos, 8'h08);

        // Forward full step from idx 0
        half_step = 1'b0;
        rf_in[0]  = 1'b1;
        wait_to(75);
        chk("dir_toggle", dir_out, 2'b01);
        chk("coil_pre_fs", coil_out, 8'h08);
        wait_to(76);
        rf_in[0] = 1'b0;
        chk("coil_fs_idx2", coil_out, 8'h04);
        chk("pos_m6", pos_out, 32'h0000_FFFA);
        chk("small_pos_a", s_pos, 8'h0A);
        wait_to(80);
        chk("coil_fs_idx4", coil_out, 8'h02);
        chk("pos_m4", pos_out, 32'h0000_FFFC);
        wait_to(84);
        chk("coil_fs_idx6", coil_out, 8'h01);
        chk("pos_m2_fwd", pos_out, 32'h0000_FFFE);
        wait_to(88);
        chk("coil_fs_idx0", coil_out, 8'h08);
        chk("pos_wrap_zero", pos_out, 32'h0000_0000);
        wait_to(100);
        chk("small_pos_6", s_pos, 8'h06);
        wait_to(104);
        chk("pos_p8", pos_out, 32'h0000_0008);
        chk("small_pos_signed_wrap", s_pos, 8'h08);
        chk("small_coil", s_coil, 8'h08);
        chk("small_en_dir", {s_en, s_dir}, 4'b0101);

        // ch1 forward into limit, ch0 disabled, all in one cycle
        limit_sw[1] = 1'b1;
        rf_in       = 4'b1110;
        wait_to(107);
        chk("en_multi_toggle", en_out, 2'b10);
        chk("dir_multi_toggle", dir_out, 2'b11);
        chk("coil_ch0_off_ch1_on", coil_out, 8'h80);
        chk("pos_frozen_a", pos_out, 32'h0000_0008);
        wait_to(109);
        rf_in = 4'b0000;
        wait_to(112);
        chk("coil_limit_hold", coil_out, 8'h80);
        chk("pos_limit_hold", pos_out, 32'h0000_0008);
        chk("en_limit_kept", en_out, 2'b10);

        // Reverse off the limit
        rf_in[2] = 1'b1;
        wait_to(115);
        chk("dir1_rev", dir_out, 2'b01);
        chk("coil_rev_pre", coil_out, 8'h80);
        wait_to(116);
        rf_in[2] = 1'b0;
        chk("coil_rev_idx6", coil_out, 8'h10);
        chk("pos_rev_m2", pos_out, 32'hFFFE_0008);
        wait_to(120);
        chk("coil_rev_idx4", coil_out, 8'h20);
        chk("pos_rev_m4", pos_out, 32'hFFFC_0008);
        limit_sw[1] = 1'b0;

        // Toggle edge coincident with tick
        wait_to(121);
        rf_in[2] = 1'b1;
        wait_to(123);
        chk("dir_pre_coinc", dir_out, 2'b01);
        wait_to(124);
        chk("dir_post_coinc", dir_out, 2'b11);
        chk("coil_old_dir", coil_out, 8'h40);
        chk("pos_old_dir", pos_out, 32'hFFFA_0008);
        wait_to(126);
        rf_in[2] = 1'b0;
        wait_to(128);
        chk("coil_new_dir", coil_out, 8'h20);
        chk("pos_new_dir", pos_out, 32'hFFFC_0008);
        chk("small_pos_ch", s_pos, 8'hC8);

        // Asynchronous reset mid-motion
        wait_to(130);
        #3 rst = 1'b0;
        #1;
        chk("async_reset_outs", {coil_out, en_out, dir_out, pos_out}, 64'd0);
        @(posedge clk);
        #1;
        chk("reset_held_outs", {coil_out, en_out, dir_out, pos_out}, 64'd0);
        rst       = 1'b1;
        edges     = 0;
        half_step = 1'b1;
        rf_in[1]  = 1'b1;
        wait_to(3);
        chk("post_rst_en", en_out, 2'b01);
        chk("post_rst_coil", coil_out, 8'h08);
        chk("post_rst_pos", pos_out, 32'h0);
        wait_to(4);
        chk("first_tick_coil", coil_out, 8'h09);
        chk("first_tick_pos", pos_out, 32'h0000_FFFF);
        wait_to(5);
        rf_in[1] = 1'b0;
        wait_to(7);
        chk("second_tick_pre", coil_out, 8'h09);
        wait_to(8);
        chk("second_tick_coil", coil_out, 8'h01);
        chk("second_tick_pos", pos_out, 32'h0000_FFFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_stepper_controller.md
# multi_stepper_controller

Parametrised N-channel stepper motor controller, the successor to the fixed two-motor full-step interface. Per channel it toggle-latches direction and enable from debounced RF button pulses, gates motion with a limit switch, and produces unipolar coil patterns in full-step or half-step mode at a programmable step rate. It also maintains a signed position count. It sits between the RF receiver / limit-switch pins and the PmodSTEP coil drivers, and replaces the separate clock divider and per-motor drivers.

## Interface
- NUM_CH, 2, number of motor channels (1..8)
- STEP_DIV, 1_000_000, clk cycles per step tick (>= 2)
- DIV_W, 24, tick counter width; must satisfy 2^DIV_W >= STEP_DIV
- POS_W, 16, position counter width
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rf_in  in  2*NUM_CH  bit 2i = direction toggle for channel i, bit 2i+1 = enable toggle for channel i; asynchronous
- limit_sw  in  NUM_CH  forward limit switch per channel, active-high; asynchronous
- half_step  in  1  global mode: 0 = full step, 1 = half step; synchronous, sampled on each tick
- coil_out  out  4*NUM_CH  coil pattern, bits 4i+3..4i for channel i
- dir_out  out  NUM_CH  latched direction per channel (1 = forward)
- en_out  out  NUM_CH  latched enable per channel
- pos_out  out  POS_W*NUM_CH  signed position per channel

## Operation
- **Input conditioning:** rf_in and limit_sw each pass through two synchronising flops. rf_in is then rising-edge detected against a third delayed copy.
- **Toggles:** a direction-edge pulse inverts dir[i]; an enable-edge pulse inverts en[i]. Holding a button produces exactly one toggle.
- **Tick generator:** shared counter runs 0..STEP_DIV-1. The tick is a 1-cycle strobe while count == STEP_DIV-1; the counter then wraps to 0.
- **Step condition on a tick:** en[i]=1 and not (limit_sync[i]=1 and dir[i]=1). Reverse motion is always permitted off the limit. The en latch is never modified by the limit.
- **Phase index:** 3-bit idx, 0..7, wrap-around modulo 8.
  - Step size: ±1 in half-step mode, ±2 in full-step mode.
  - Sign: + when dir=1, − when dir=0.
  - Changing mode preserves idx and its parity.
- **Coil table (idx → coil[3:0]):** 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001.
- **Coil output:** coil_out = table[idx] when en=1. coil_out = 0000 when en=0 (coils de-energised); idx is retained.
- **Position:** pos changes by the same signed amount as idx on every step and wraps modulo 2^POS_W.
- **Reset values:** dir=0, en=0, idx=0, pos=0, coil_out=0000, tick counter=0, all sync flops 0. Reset mid-motion de-energises the coils immediately (asynchronous).

## Timing
- rf_in rising, meeting setup at edge 0: the edge pulse is asserted during the cycle after edge 1, and dir_out/en_out change at edge 2.
- A tick asserted in cycle k: idx, pos and coil_out update at the clk edge that ends cycle k.
- en_out falling: coil_out becomes 0000 in the same cycle (combinational on registered en).
- Step rate: one step per STEP_DIV cycles. The first tick after reset is in cycle STEP_DIV-1.
- Toggle edge coincident with a tick: the step uses the pre-toggle dir/en. The new value governs the next tick.
- Limit assertion coincident with a tick: the step is decided on limit_sync, i.e. 2 cycles behind the pin.
- Both toggle bits of a channel in the same cycle: both take effect.
- Channels are fully independent.

## Structure
- Package stepper_pkg holds:
  - the 8-entry coil table constant
  - the step-size constants (HALF=1, FULL=2)
  - the per-channel bit-slice offsets
- Sub-module stepper_channel contains, for one channel:
  - sync/edge logic
  - dir/en latches
  - limit gating
  - idx/pos registers
  - coil lookup
- The top level contains the shared tick counter and a generate loop of NUM_CH stepper_channel instances.

## Test plan
All tests use STEP_DIV=4 and NUM_CH=2.
- Reset, then no stimulus for 40 cycles → coil_out=0, en_out=0, dir_out=0, pos_out=0 throughout.
- Pulse rf_in[1] for 5 cycles, half_step=1, dir=0 → en_out[0] rises at edge 2 and stays 1 (single toggle). Channel 0 coil_out then steps 1000→1001→0001…, one change per 4 cycles, and pos decrements by 1 per step.
- Pulse rf_in[0] with ch0 enabled, half_step=0, starting idx=0 → idx sequence 0,2,4,6,0; coil 1000,0100,0010,0001,1000; pos +2 per tick, wrapping 0x7FFE→−0x8000.
- Enable ch1 forward with limit_sw[1]=1 → no coil change and pos frozen, while en_out[1]=1 and coil holds its pattern. Toggle dir to 0 → stepping resumes in reverse.
- Toggle pulse whose edge detect coincides with a tick → that step uses the old direction, and the next tick uses the new one.
- Assert rst mid-stepping between clock edges → all outputs go to reset values immediately, without waiting for clk. After release, the first tick occurs at cycle 3.
